// File: rtl/pb_event_pkg.sv
// Shared event-type codes and per-button FSM state encodings for the push-button event scheduler.
package pb_event_pkg;

    typedef logic [1:0] evt_type_t;

    localparam evt_type_t EVT_NONE   = 2'b00;
    localparam evt_type_t EVT_SHORT  = 2'b01;
    localparam evt_type_t EVT_LONG   = 2'b10;
    localparam evt_type_t EVT_REPEAT = 2'b11;

    localparam logic [1:0] PBS_IDLE      = 2'b00;
    localparam logic [1:0] PBS_HELD      = 2'b01;
    localparam logic [1:0] PBS_LONG_HELD = 2'b10;

endpackage

// File: rtl/pb_press_classifier.sv
// One button: press FSM, hold counter and single-entry pending slot.
// Optional auto-repeat of LONG presses when PB_AUTOREPEAT_EN is defined.
module pb_press_classifier
    import pb_event_pkg::*;
#(
    parameter int unsigned HOLD_WIDTH        = 26,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned REPEAT_CYCLES     = 10_000_000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      pb_posedge,
    input  logic      pb_negedge,
    input  logic      slot_clear,
    output logic      slot_valid,
    output evt_type_t slot_type,
    output logic      drop
);

    localparam logic [HOLD_WIDTH-1:0] LONG_LAST = HOLD_WIDTH'(LONG_PRESS_CYCLES - 1);

    logic [1:0]            state, state_nxt;
    logic [HOLD_WIDTH-1:0] cnt, cnt_nxt;
    logic                  post;
    evt_type_t             post_type;
    logic                  pos, neg;

    // Coincident press and release pulses cancel each other.
    assign pos = pb_posedge & ~pb_negedge;
    assign neg = pb_negedge & ~pb_posedge;

`ifdef PB_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rcnt, rcnt_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        post      = 1'b0;
        post_type = EVT_SHORT;
`ifdef PB_AUTOREPEAT_EN
        rcnt_nxt  = rcnt;
`endif
        case (state)
            PBS_IDLE: begin
                if (pos) begin
                    state_nxt = PBS_HELD;
                    cnt_nxt   = '0;
                end
            end
            PBS_HELD: begin
                if (neg) begin
                    state_nxt = PBS_IDLE;
                    post      = 1'b1;
                    post_type = EVT_SHORT;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = PBS_LONG_HELD;
                    post      = 1'b1;
                    post_type = EVT_LONG;
`ifdef PB_AUTOREPEAT_EN
                    rcnt_nxt  = '0;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PBS_LONG_HELD: begin
                if (neg) begin
                    state_nxt = PBS_IDLE;
`ifdef PB_AUTOREPEAT_EN
                end else if (rcnt == RPT_LAST) begin
                    post      = 1'b1;
                    post_type = EVT_REPEAT;
                    rcnt_nxt  = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
`endif
                end
            end
            default: state_nxt = PBS_IDLE;
        endcase
    end

    // A drain in the same cycle frees the slot for the new event.
    assign drop = post & slot_valid & ~slot_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PBS_IDLE;
            cnt        <= '0;
            slot_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (post && !drop) begin
                slot_valid <= 1'b1;
            end else if (slot_clear) begin
                slot_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (post && !drop) begin
            slot_type <= post_type;
        end
    end

`ifdef PB_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_nxt;
        end
    end
`endif

endmodule

// File: rtl/pb_event_scheduler.sv
// Classifies button presses and serialises pending events onto one valid/ready stream, round-robin.
// Define PB_AUTOREPEAT_EN to enable REPEAT events while a button is held past the LONG threshold.
module pb_event_scheduler
    import pb_event_pkg::*;
#(
    parameter int unsigned NUM_PB            = 4,
    parameter int unsigned HOLD_WIDTH        = 26,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned REPEAT_CYCLES     = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PB-1:0]         pb_posedge,
    input  logic [NUM_PB-1:0]         pb_negedge,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_PB)-1:0] evt_id,
    output evt_type_t                 evt_type,
    output logic [NUM_PB-1:0]         pending,
    output logic                      overflow
);

    localparam int unsigned ID_W = $clog2(NUM_PB);

    logic [NUM_PB-1:0] slot_valid, slot_clear, drop;
    evt_type_t         slot_type [NUM_PB];
    logic [ID_W-1:0]   rr_ptr, grant_id;
    logic              grant_vld, load;

    for (genvar g = 0; g < NUM_PB; g++) begin : g_btn
        pb_press_classifier #(
            .HOLD_WIDTH       (HOLD_WIDTH),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_cls (
            .clk       (clk),
            .rst       (rst),
            .pb_posedge(pb_posedge[g]),
            .pb_negedge(pb_negedge[g]),
            .slot_clear(slot_clear[g]),
            .slot_valid(slot_valid[g]),
            .slot_type (slot_type[g]),
            .drop      (drop[g])
        );
    end

    assign pending = slot_valid;
    assign load    = ~evt_valid | evt_ready;

    // First occupied slot at or after the pointer, wrapping modulo NUM_PB.
    always_comb begin
        logic [ID_W:0] sum;
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (sum >= (ID_W + 1)'(NUM_PB)) begin
                sum = sum - (ID_W + 1)'(NUM_PB);
            end
            if (!grant_vld && slot_valid[sum[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        slot_clear = '0;
        if (load && grant_vld) begin
            slot_clear[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= EVT_NONE;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= |drop;
            if (load) begin
                evt_valid <= grant_vld;
                if (grant_vld) begin
                    evt_id   <= grant_id;
                    evt_type <= slot_type[grant_id];
                    rr_ptr   <= (grant_id == ID_W'(NUM_PB - 1)) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pb_event_scheduler.sv
// Scoreboard bench for pb_event_scheduler: directed presses push expected events, a monitor pops them.
module tb_pb_event_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] pb_posedge;
    logic [3:0] pb_negedge;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic [3:0] pending;
    logic       overflow;

    pb_event_scheduler #(
        .NUM_PB           (4),
        .HOLD_WIDTH       (26),
        .LONG_PRESS_CYCLES(20),
        .REPEAT_CYCLES    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_posedge(pb_posedge),
        .pb_negedge(pb_negedge),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .pending   (pending),
        .overflow  (overflow)
    );

    typedef struct {
        int         id;
        logic [1:0] typ;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc     = 0;
    int   ntests  = 0;
    int   nfail   = 0;
    int   ovf_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int t, input logic [3:0] pos, input logic [3:0] neg);
        go(t);
        pb_posedge = pos;
        pb_negedge = neg;
        go(t + 1);
        pb_posedge = '0;
        pb_negedge = '0;
    endtask

    task automatic expect_evt(input int id, input logic [1:0] typ, input int c);
        exp_t x;
        x.id  = id;
        x.typ = typ;
        x.cyc = c;
        sb.push_back(x);
    endtask

    // Monitor: compare every presented event against the scoreboard head.
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cnt++;
        if (evt_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_evt_id", {30'd0, evt_id}, 32'hFFFF_FFFF);
            end else begin
                e = sb[0];
                chk("evt_id", {30'd0, evt_id}, e.id);
                chk("evt_type", {30'd0, evt_type}, {30'd0, e.typ});
                if (evt_ready) begin
                    chk("evt_cycle", cyc, e.cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        pb_posedge = '0;
        pb_negedge = '0;
        evt_ready  = 1'b1;
        go(2);
        chk("rst_evt_valid", {31'd0, evt_valid}, 0);
        chk("rst_pending", {28'd0, pending}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_evt_id", {30'd0, evt_id}, 0);
        chk("rst_evt_type", {30'd0, evt_type}, 0);
        go(3);
        rst = 1'b0;

        // Short press on button 2
        pulse(110, 4'b0100, 4'b0000);
        expect_evt(2, 2'b01, 117);
        pulse(115, 4'b0000, 4'b0100);
        chk("short_pending", {28'd0, pending}, 32'h4);

        // Long press on button 0, release produces nothing
        pulse(210, 4'b0001, 4'b0000);
        expect_evt(0, 2'b10, 232);
        pulse(245, 4'b0000, 4'b0001);

        // Simultaneous shorts on 1 and 3, then 0 and 3, then all four
        pulse(305, 4'b1010, 4'b0000);
        expect_evt(1, 2'b01, 312);
        expect_evt(3, 2'b01, 313);
        pulse(310, 4'b0000, 4'b1010);
        pulse(355, 4'b1001, 4'b0000);
        expect_evt(0, 2'b01, 362);
        expect_evt(3, 2'b01, 363);
        pulse(360, 4'b0000, 4'b1001);
        pulse(400, 4'b1111, 4'b0000);
        expect_evt(0, 2'b01, 407);
        expect_evt(1, 2'b01, 408);
        expect_evt(2, 2'b01, 409);
        expect_evt(3, 2'b01, 410);
        pulse(405, 4'b0000, 4'b1111);

        // Backpressure: third press on button 0 is dropped
        go(500);
        evt_ready = 1'b0;
        pulse(503, 4'b0001, 4'b0000);
        expect_evt(0, 2'b01, 530);
        pulse(506, 4'b0000, 4'b0001);
        pulse(509, 4'b0001, 4'b0000);
        expect_evt(0, 2'b01, 531);
        pulse(512, 4'b0000, 4'b0001);
        pulse(515, 4'b0001, 4'b0000);
        chk("bp_overflow_before", {31'd0, overflow}, 0);
        pulse(518, 4'b0000, 4'b0001);
        go(519);
        chk("bp_overflow_pulse", {31'd0, overflow}, 1);
        go(520);
        chk("bp_overflow_end", {31'd0, overflow}, 0);
        go(525);
        chk("bp_pending", {28'd0, pending}, 32'h1);
        chk("bp_evt_valid", {31'd0, evt_valid}, 1);
        chk("bp_ovf_count", ovf_cnt, 1);
        go(530);
        evt_ready = 1'b1;

        // Reset in the middle of a hold discards the press
        pulse(610, 4'b0010, 4'b0000);
        go(615);
        rst = 1'b1;
        go(616);
        rst = 1'b0;
        pulse(618, 4'b0000, 4'b0010);
        go(630);
        chk("rsthold_pending", {28'd0, pending}, 0);
        chk("rsthold_evt_valid", {31'd0, evt_valid}, 0);

        // 45-cycle hold on button 3
        pulse(710, 4'b1000, 4'b0000);
        expect_evt(3, 2'b10, 732);
`ifdef PB_AUTOREPEAT_EN
        expect_evt(3, 2'b11, 740);
        expect_evt(3, 2'b11, 748);
        expect_evt(3, 2'b11, 756);
`endif
        pulse(755, 4'b0000, 4'b1000);

        // Release on the threshold cycle gives SHORT; coincident edges and idle release are ignored
        pulse(810, 4'b0010, 4'b0000);
        expect_evt(1, 2'b01, 832);
        pulse(830, 4'b0000, 4'b0010);
        pulse(850, 4'b0100, 4'b0100);
        pulse(855, 4'b0000, 4'b0100);
        go(870);
        chk("ignored_pending", {28'd0, pending}, 0);

        go(900);
        chk("sb_drained", sb.size(), 0);
        chk("total_ovf_count", ovf_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/pb_event_scheduler.md
Name: pb_event_scheduler

Overview:
- Collects the debounced edge pulses from NUM_PB push-button debouncers and classifies each press as a SHORT or LONG press.
- Buffers one pending event per button.
- Serialises the pending events onto a single valid/ready event stream using round-robin arbitration.
- Sits between the button debouncer bank and downstream consumers such as the sequence detector or the menu/UI FSM.

Parameters:
- NUM_PB, 4: number of buttons; must be at least 2.
- HOLD_WIDTH, 26: width of the per-button hold counter.
- LONG_PRESS_CYCLES, 50_000_000: number of cycles held before a press counts as LONG; range 2 to 2^HOLD_WIDTH-1.
- REPEAT_CYCLES, 10_000_000: auto-repeat period in cycles; used only when PB_AUTOREPEAT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pb_posedge  in  NUM_PB  per-button debounced press pulse, 1 cycle
- pb_negedge  in  NUM_PB  per-button debounced release pulse, 1 cycle
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event
- evt_id  out  $clog2(NUM_PB)  index of the button that produced the event
- evt_type  out  2  01 SHORT, 10 LONG, 11 REPEAT
- pending  out  NUM_PB  per-button pending-slot occupancy
- overflow  out  1  1-cycle pulse when an event is dropped

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All button FSMs go to IDLE, hold counters to 0, pending to 0, evt_valid/evt_id/evt_type/overflow to 0, round-robin pointer to 0. Reset mid-press discards the press; a later negedge from IDLE is ignored.
- Per-button FSM states:
  - IDLE: posedge -> HELD, counter <= 0.
  - HELD: counter increments each cycle.
    - negedge -> IDLE and post a SHORT event.
    - else if counter == LONG_PRESS_CYCLES-1 -> LONG_HELD and post a LONG event.
    - A negedge in the same cycle as the threshold yields SHORT.
  - LONG_HELD: negedge -> IDLE, no event.
  - Posedge in HELD or LONG_HELD is ignored. Negedge in IDLE is ignored.
  - Posedge and negedge asserted in the same cycle are both ignored.
- Hold counter does not wrap: it saturates at the threshold and stops outside HELD.
- Pending slot (one per button):
  - A posted event is written to the slot (valid + type) at the clock edge that samples the pulse or threshold.
  - Slot full and not being drained this cycle -> the new event is dropped and overflow pulses for 1 cycle.
  - Slot drained and a new event posted in the same cycle -> the new event is stored (no drop).
- Output register:
  - Loads when evt_valid==0 or (evt_valid && evt_ready).
  - Source is the first pending button found by searching from the pointer upward, mod NUM_PB.
  - On load: that pending slot is cleared and pointer <= granted id + 1 (mod NUM_PB).
  - No pending slot -> evt_valid <= 0 (or stays 0).
- Latency and hold rules:
  - Event pulse in cycle k with the output free -> evt_valid in cycle k+2.
  - Sustained throughput is 1 event per cycle when evt_ready==1.
  - evt_id/evt_type are held stable while evt_valid && !evt_ready.
- Multiple overflows in the same cycle produce a single overflow pulse.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined: in LONG_HELD, a per-button repeat counter posts a REPEAT event every REPEAT_CYCLES. The first REPEAT comes REPEAT_CYCLES after the LONG event. The repeat counter clears on entering LONG_HELD. Dropped REPEATs pulse overflow like any other drop.
- Not defined: no repeat counter logic; evt_type 11 is never produced; REPEAT_CYCLES is unused.

Decomposition:
- Package pb_event_pkg: EVT_SHORT=2'b01, EVT_LONG=2'b10, EVT_REPEAT=2'b11; button-FSM state encodings PBS_IDLE, PBS_HELD, PBS_LONG_HELD.
- Sub-module pb_press_classifier: per-button FSM, hold/repeat counters and pending slot, with a clear input from the arbiter and an overflow output. Instantiated NUM_PB times via generate.
- Top module holds the round-robin search, the pointer and the output register.

Test Plan (NUM_PB=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8, evt_ready=1 unless stated):
- Short press: posedge[2] at cycle 10, negedge[2] at 15 -> evt_valid for exactly cycle 17; id=2, type=01.
- Long press: posedge[0] at cycle 10, negedge[0] at 45 -> a single event with evt_valid in cycle 32, id=0, type=10; the release produces nothing.
- Arbitration: pointer=0; SHORT events complete on buttons 1 and 3 in the same cycle -> id=1, then id=3 on consecutive cycles; pointer ends at 0.
- Backpressure and overflow: evt_ready=0; three short presses on button 0 -> first event in the output register, second pending, third dropped with a 1-cycle overflow pulse. After evt_ready=1, exactly 2 events are delivered.
- Reset mid-hold: posedge[1] at 10, rst at 15, negedge[1] at 18 -> evt_valid stays 0 and pending stays 0.
- PB_AUTOREPEAT_EN defined: hold button 3 for 45 cycles from posedge at cycle 10 -> LONG at cycle 32, then REPEATs at cycles 40, 48 and 56; nothing after the release.
